score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Upstream of the scoreboard digit renderer: converts game-logic point events into a two-digit BCD score.
- Tears nothing on screen: the live score is copied to the display outputs only once per frame, at a fixed scanline.
- Also tracks a win condition and rejects repeat points caused by a collision that lasts several frames.
- Sits between the game/collision logic and the scoreboard pixel generator; shares the Hcount/Vcount bus with it.

Parameters:
- WIN_SCORE, 10, decimal score (0..99) at which win asserts; further points are then ignored.
- LATCH_LINE, 480, Vcount value (first blanking line) at which the display copy is taken.
- HOLDOFF_FRAMES, 2, frames after an accepted point during which new point edges are discarded (0 = no holdoff).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- Hcount  in  16  horizontal pixel counter from the VGA timing generator.
- Vcount  in  16  vertical line counter from the VGA timing generator.
- point  in  1  level from collision logic; may stay high for many cycles.
- clear_score  in  1  single-cycle synchronous restart request.
- ones  out  4  displayed units digit, BCD.
- tens  out  4  displayed tens digit, BCD.
- win  out  1  displayed win flag.

Behaviour:
- Reset (synchronous, active-high; clk and reset named as in codebase): live digits 0/0, ones=0, tens=0, win=0, holdoff counter 0, point edge register 0, state PLAY.
- frame_tick: one-cycle pulse when Hcount==0 && Vcount==LATCH_LINE (registered compare; asserts cycle after match).
- Point edge: point_q registered each cycle; rise = point & ~point_q. A level held high counts once.
- States:
  - PLAY: rise with holdoff==0 -> increment live BCD; holdoff loads HOLDOFF_FRAMES. Rise with holdoff!=0 -> discarded.
  - WIN: entered in the cycle after live score becomes >= WIN_SCORE. All rises ignored. Leave only via clear_score or reset.
- BCD increment: ones 9 -> 0 with tens+1. At 99, saturate (no wrap to 00). Digits never leave 0..9.
- Holdoff: decrements by 1 on each frame_tick while nonzero; never underflows.
- Display latch: on frame_tick, ones<=live_ones, tens<=live_tens, win<=(state==WIN). Outputs are otherwise stable for the whole frame.
- Latency: a rise reaches the outputs at the next frame_tick (up to one frame).
- clear_score:
  - Live digits go to 0, holdoff goes to 0, state goes to PLAY in the next cycle.
  - Display outputs clear at the next frame_tick, not immediately.
- Simultaneous events:
  - clear_score + rise in the same cycle: clear wins, the point is dropped.
  - rise + frame_tick in the same cycle: the latch takes the pre-increment value; the increment shows next frame.
  - clear_score + frame_tick in the same cycle: the latch takes the pre-clear value.
- Reset mid-frame clears the outputs immediately, with no wait for frame_tick.

Optional Feature:
- Macro SCORE_BIN_EN.
- Defined: adds output score_bin [6:0], the live score in binary (0..99), updated the same cycle as the live BCD digits, reset 0, cleared by clear_score.
- Not defined: port and its logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - state enum PLAY/WIN.
  - BCD_W=4.
  - COORD_W=16 (Hcount/Vcount width, shared with scoreboard and VGA timing).
  - Default LATCH_LINE and WIN_SCORE constants.
- One natural sub-module: bcd_digit_counter. It is a single saturating-aware BCD digit with inc, clear, carry_out; instantiated twice, the tens carry gated for saturation.

Test Plan:
- After reset, drive Hcount/Vcount through one frame -> ones=0, tens=0, win=0; no change at frame_tick.
- point high for 3 full frames, HOLDOFF_FRAMES=2 -> exactly one increment; ones=1 after the first frame_tick; tens=0.
- 10 isolated point pulses spaced 3 frames apart, WIN_SCORE=10 -> tens=1, ones=0, win=1 at the frame_tick after the 10th; an 11th pulse leaves the score at 10.
- WIN_SCORE=99, preload to 99 via pulses, one more pulse -> output remains 9/9 and does not wrap to 00.
- clear_score in the same cycle as a point rise, score 5 -> live 0; display shows 5 until the next frame_tick, then 0; the dropped point never appears.
- Point rise in the same cycle as frame_tick at score 3 -> display 3 this frame, 4 the next.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the scoreboard score path.
// Hcount/Vcount width is common with the scoreboard renderer and VGA timing.
package score_keeper_pkg;

  localparam int unsigned BCD_W              = 4;
  localparam int unsigned COORD_W            = 16;
  localparam int unsigned SCORE_W            = 7;
  localparam int unsigned DEF_WIN_SCORE      = 10;
  localparam int unsigned DEF_LATCH_LINE     = 480;
  localparam int unsigned DEF_HOLDOFF_FRAMES = 2;

  typedef enum logic [0:0] {
    StPlay,
    StWin
  } state_e;

  // tens*10 + ones without a multiplier
  function automatic logic [SCORE_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] tens_dig,
                                                    input logic [BCD_W-1:0] ones_dig);
    logic [SCORE_W-1:0] t;
    t = SCORE_W'(tens_dig);
    return (t << 3) + (t << 1) + SCORE_W'(ones_dig);
  endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_counter.sv
// Single BCD digit (0..9). carry_out flags an increment that would wrap 9->0;
// enable lets the parent freeze the digit when the whole score saturates.
module bcd_digit_counter
  import score_keeper_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             enable,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  logic [BCD_W-1:0] digit_q, digit_d;

  // carry does not depend on enable, so a saturation gate fed from it cannot loop
  always_comb begin
    carry_out = inc & (digit_q >= BCD_W'(9));
  end

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (inc && enable) begin
      digit_d = (digit_q >= BCD_W'(9)) ? '0 : digit_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

  digit_range_a: assert property (@(posedge clk) disable iff (reset) digit_q <= BCD_W'(9));

endmodule

// File: rtl/score_keeper.sv
// Point events -> two-digit BCD score, copied to the display once per frame.
// Optional binary score output enabled by defining SCORE_BIN_EN.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = DEF_WIN_SCORE,
  parameter int unsigned LATCH_LINE     = DEF_LATCH_LINE,
  parameter int unsigned HOLDOFF_FRAMES = DEF_HOLDOFF_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] Hcount,
  input  logic [COORD_W-1:0] Vcount,
  input  logic               point,
  input  logic               clear_score,
  output logic [BCD_W-1:0]   ones,
  output logic [BCD_W-1:0]   tens,
  output logic               win
`ifdef SCORE_BIN_EN
  ,
  output logic [SCORE_W-1:0] score_bin
`endif
);

  localparam int unsigned HoldW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  logic               point_q;
  logic               tick_q, tick_d;
  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [BCD_W-1:0]   live_ones, live_tens;
  logic               ones_carry, tens_carry;
  logic [SCORE_W-1:0] live_score;
  logic               rise, reached_win, accept;

  always_comb begin
    tick_d      = (Hcount == '0) && (Vcount == COORD_W'(LATCH_LINE));
    rise        = point & ~point_q;
    live_score  = bcd_to_bin(live_tens, live_ones);
    reached_win = 32'(live_score) >= WIN_SCORE;
    // clear beats a coincident rise; the win check also covers the cycle before WIN is entered
    accept      = rise & ~clear_score & (state_q == StPlay) & (hold_q == '0) & ~reached_win;
  end

  // tens_carry high means this point would wrap 99 -> 00, so both digits hold
  bcd_digit_counter u_ones (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_score),
    .inc      (accept),
    .enable   (~tens_carry),
    .digit    (live_ones),
    .carry_out(ones_carry)
  );

  bcd_digit_counter u_tens (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_score),
    .inc      (ones_carry),
    .enable   (~tens_carry),
    .digit    (live_tens),
    .carry_out(tens_carry)
  );

  always_comb begin
    hold_d = hold_q;
    if (clear_score) begin
      hold_d = '0;
    end else if (accept) begin
      hold_d = HoldW'(HOLDOFF_FRAMES);
    end else if (tick_q && (hold_q != '0)) begin
      hold_d = hold_q - HoldW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPlay: begin
        if (!clear_score && reached_win) begin
          state_d = StWin;
        end
      end
      StWin: begin
        if (clear_score) begin
          state_d = StPlay;
        end
      end
    endcase
  end

  // Display copy uses pre-update live values, so same-cycle rises/clears show next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      point_q <= 1'b0;
      tick_q  <= 1'b0;
      state_q <= StPlay;
      hold_q  <= '0;
      ones    <= '0;
      tens    <= '0;
      win     <= 1'b0;
    end else begin
      point_q <= point;
      tick_q  <= tick_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      if (tick_q) begin
        ones <= live_ones;
        tens <= live_tens;
        win  <= (state_q == StWin);
      end
    end
  end

`ifdef SCORE_BIN_EN
  assign score_bin = live_score;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: table of pulse counts, hand corner sequences and random
// traffic, all checked every cycle against an integer-level score model.
module tb_score_keeper;

  localparam int FL = 20;  // cycles per bench frame

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Hcount = '0;
  logic [15:0] Vcount = '0;
  logic        point = 1'b0;
  logic        clear_score = 1'b0;
  logic [3:0]  ones10, tens10, ones99, tens99;
  logic        win10, win99;
`ifdef SCORE_BIN_EN
  logic [6:0]  bin10, bin99;
`endif

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(10), .LATCH_LINE(480), .HOLDOFF_FRAMES(2)) dut10 (
    .clk        (clk),
    .reset      (reset),
    .Hcount     (Hcount),
    .Vcount     (Vcount),
    .point      (point),
    .clear_score(clear_score),
    .ones       (ones10),
    .tens       (tens10),
    .win        (win10)
`ifdef SCORE_BIN_EN
    ,
    .score_bin  (bin10)
`endif
  );

  score_keeper #(.WIN_SCORE(99), .LATCH_LINE(480), .HOLDOFF_FRAMES(0)) dut99 (
    .clk        (clk),
    .reset      (reset),
    .Hcount     (Hcount),
    .Vcount     (Vcount),
    .point      (point),
    .clear_score(clear_score),
    .ones       (ones99),
    .tens       (tens99),
    .win        (win99)
`ifdef SCORE_BIN_EN
    ,
    .score_bin  (bin99)
`endif
  );

  typedef struct {
    int score;
    int hold;
    bit won;
    bit prev;
    bit tick;
    int d_ones;
    int d_tens;
    bit d_win;
  } model_t;

  typedef struct {
    int         n_pulses;
    logic [3:0] e_ones;
    logic [3:0] e_tens;
    logic       e_win;
  } vec_t;

  model_t m10, m99;
  int     total = 0;
  int     bad = 0;
  int     fpos = 0;
  bit     checking = 0;
  vec_t   vecs[6];

  // Score kept as a plain integer; digits only derived when the display copy happens.
  function automatic model_t mstep(model_t m, int ws, int hf, bit rst, bit pt, bit clr,
                                   int h, int v);
    model_t n;
    bit r;
    n = m;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if (m.tick) begin
      n.d_ones = m.score % 10;
      n.d_tens = m.score / 10;
      n.d_win  = m.won;
    end
    r = pt && !m.prev;
    if (clr) begin
      n.score = 0;
      n.hold  = 0;
      n.won   = 0;
    end else begin
      if (!m.won && m.score >= ws) n.won = 1;
      if (r && !m.won && m.hold == 0 && m.score < ws) begin
        n.score = (m.score < 99) ? m.score + 1 : 99;
        n.hold  = hf;
      end else if (m.tick && m.hold > 0) begin
        n.hold = m.hold - 1;
      end
    end
    n.prev = pt;
    n.tick = (h == 0) && (v == 480);
    return n;
  endfunction

  function automatic logic [8:0] expv(model_t m);
    return {4'(m.d_ones), 4'(m.d_tens), m.d_win};
  endfunction

  task automatic cmp(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got{ones,tens,win}=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    if (fpos == 0) begin
      Hcount = 16'd0;
      Vcount = 16'd480;
    end else if ($urandom_range(0, 1) == 0) begin
      Hcount = 16'd0;
      Vcount = 16'($urandom_range(0, 479));
    end else begin
      Hcount = 16'($urandom_range(1, 799));
      Vcount = ($urandom_range(0, 1) == 0) ? 16'd480 : 16'($urandom_range(0, 524));
    end
    @(posedge clk);
    m10 = mstep(m10, 10, 2, reset, point, clear_score, int'(Hcount), int'(Vcount));
    m99 = mstep(m99, 99, 0, reset, point, clear_score, int'(Hcount), int'(Vcount));
    fpos = (fpos + 1) % FL;
    #1;
    if (checking) begin
      cmp("cycle_w10", {ones10, tens10, win10}, expv(m10));
      cmp("cycle_w99", {ones99, tens99, win99}, expv(m99));
`ifdef SCORE_BIN_EN
      cmp("bin_w10", {2'b0, bin10}, 9'(m10.score));
      cmp("bin_w99", {2'b0, bin99}, 9'(m99.score));
`endif
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_frames(input int k);
    run_cycles(k * FL);
  endtask

  task automatic align(input int p);
    while (fpos != p) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run_cycles(2);
    reset = 1'b0;
    checking = 1;
  endtask

  task automatic pulse();
    point = 1'b1;
    step();
    point = 1'b0;
    wait_frames(3);
  endtask

  initial begin
    vecs[0] = '{0,  4'd0, 4'd0, 1'b0};
    vecs[1] = '{1,  4'd1, 4'd0, 1'b0};
    vecs[2] = '{3,  4'd3, 4'd0, 1'b0};
    vecs[3] = '{9,  4'd9, 4'd0, 1'b0};
    vecs[4] = '{10, 4'd0, 4'd1, 1'b1};
    vecs[5] = '{12, 4'd0, 4'd1, 1'b1};

    // Idle frame after reset: outputs stay zero through the latch
    do_reset();
    wait_frames(1);
    cmp("reset_frame", {ones10, tens10, win10}, 9'h000);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int p = 0; p < vecs[i].n_pulses; p++) pulse();
      wait_frames(1);
      cmp($sformatf("table_row%0d", i), {ones10, tens10, win10},
          {vecs[i].e_ones, vecs[i].e_tens, vecs[i].e_win});
    end

    // Level held for three frames counts once
    do_reset();
    align(5);
    point = 1'b1;
    wait_frames(1);
    cmp("held_first_frame", {ones10, tens10, win10}, {4'd1, 4'd0, 1'b0});
    wait_frames(2);
    point = 1'b0;
    wait_frames(3);
    cmp("held_three_frames", {ones10, tens10, win10}, {4'd1, 4'd0, 1'b0});

    // Clear together with a rise at score 5
    do_reset();
    for (int p = 0; p < 5; p++) pulse();
    align(10);
    point = 1'b1;
    clear_score = 1'b1;
    step();
    point = 1'b0;
    clear_score = 1'b0;
    cmp("clear_rise_hold5", {ones10, tens10, win10}, {4'd5, 4'd0, 1'b0});
    align(1);
    cmp("clear_before_tick", {ones10, tens10, win10}, {4'd5, 4'd0, 1'b0});
    step();
    cmp("clear_after_tick", {ones10, tens10, win10}, 9'h000);
    wait_frames(2);
    cmp("clear_point_dropped", {ones10, tens10, win10}, 9'h000);

    // Rise coincident with frame_tick at score 3
    do_reset();
    for (int p = 0; p < 3; p++) pulse();
    align(1);
    point = 1'b1;
    step();
    point = 1'b0;
    cmp("rise_tick_pre", {ones10, tens10, win10}, {4'd3, 4'd0, 1'b0});
    wait_frames(1);
    cmp("rise_tick_next", {ones10, tens10, win10}, {4'd4, 4'd0, 1'b0});

    // Clear coincident with frame_tick: latch takes pre-clear value
    align(1);
    clear_score = 1'b1;
    point = 1'b1;
    step();
    clear_score = 1'b0;
    point = 1'b0;
    cmp("clear_tick_pre", {ones10, tens10, win10}, {4'd4, 4'd0, 1'b0});
    wait_frames(1);
    cmp("clear_tick_next", {ones10, tens10, win10}, 9'h000);

    // Reset mid-frame clears outputs without waiting for the latch
    for (int p = 0; p < 2; p++) pulse();
    align(8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmp("reset_midframe", {ones10, tens10, win10}, 9'h000);

    // Saturation at 99 on the WIN_SCORE=99 instance
    do_reset();
    for (int p = 0; p < 99; p++) pulse();
    cmp("sat_99", {ones99, tens99, win99}, {4'd9, 4'd9, 1'b1});
    cmp("win10_capped", {ones10, tens10, win10}, {4'd0, 4'd1, 1'b1});
    pulse();
    wait_frames(1);
    cmp("sat_no_wrap", {ones99, tens99, win99}, {4'd9, 4'd9, 1'b1});

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) point = ~point;
      clear_score = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 1999) == 0);
      step();
    end
    reset = 1'b0;
    clear_score = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
